// File: rtl/div_iter_if.sv
// Request/response bundle between the hazard unit (master) and the EX-stage divider (slave).
interface div_iter_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;

    modport master (
        output start,
        output signed_div,
        output opdata1,
        output opdata2,
        output annul,
        input  result,
        input  ready
    );

    modport slave (
        input  start,
        input  signed_div,
        input  opdata1,
        input  opdata2,
        input  annul,
        output result,
        output ready
    );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle,
// result is {remainder, quotient} = {HI, LO} with a single-cycle ready pulse.
module div_iter #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [CNT_W-1:0]      counter;
    logic                  signed_q;
    logic                  sign1_q;
    logic                  sign2_q;
    logic [DATA_W-1:0]     quot_q;
    logic [DATA_W-1:0]     divisor_q;
    logic [DATA_W:0]       partial_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic                  op_sign1;
    logic                  op_sign2;
    logic [DATA_W-1:0]     abs1;
    logic [DATA_W-1:0]     abs2;
    logic                  accept;

    logic [DATA_W:0]       shifted;
    logic [DATA_W+1:0]     trial;
    logic                  trial_neg;
    logic [DATA_W:0]       partial_step;
    logic [DATA_W-1:0]     quot_step;
    logic                  last_step;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    // Operand magnitudes are unsigned, so the most negative value maps onto itself exactly.
    always_comb begin
        op_sign1 = bus.signed_div & bus.opdata1[DATA_W-1];
        op_sign2 = bus.signed_div & bus.opdata2[DATA_W-1];
        abs1     = op_sign1 ? (DATA_W'(0) - bus.opdata1) : bus.opdata1;
        abs2     = op_sign2 ? (DATA_W'(0) - bus.opdata2) : bus.opdata2;
        accept   = bus.start & ~bus.annul & (state == IDLE) & (bus.opdata2 != '0);
    end

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    always_comb begin
        shifted      = {partial_q[DATA_W-1:0], quot_q[DATA_W-1]};
        trial        = {1'b0, shifted} - {2'b00, divisor_q};
        trial_neg    = trial[DATA_W+1] & ~partial_q[DATA_W];
        partial_step = trial_neg ? shifted : trial[DATA_W:0];
        quot_step    = {quot_q[DATA_W-2:0], ~trial_neg};
        last_step    = (counter == CNT_W'(DATA_W - 1));
        quot_fix     = (signed_q & (sign1_q ^ sign2_q)) ? (DATA_W'(0) - quot_step) : quot_step;
        rem_fix      = (signed_q & sign1_q) ? (DATA_W'(0) - partial_step[DATA_W-1:0])
                                            : partial_step[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_next = (bus.opdata2 == '0) ? ZERO : BUSY;
                    end
                end
                ZERO: state_next = DONE;
                BUSY: begin
                    if (last_step) begin
                        state_next = DONE;
                    end
                end
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Abort leaves result untouched so HI/LO of the previous divide stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            quot_q    <= '0;
            divisor_q <= '0;
            partial_q <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (bus.annul) begin
            counter <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        signed_q  <= bus.signed_div;
                        sign1_q   <= op_sign1;
                        sign2_q   <= op_sign2;
                        quot_q    <= abs1;
                        divisor_q <= abs2;
                        partial_q <= '0;
                        counter   <= '0;
                    end
                end
                ZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                end
                BUSY: begin
                    partial_q <= partial_step;
                    quot_q    <= quot_step;
                    counter   <= counter + CNT_W'(1);
                    if (last_step) begin
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomised checks of div_iter with an expected-result scoreboard queue.
module tb_div_iter;

    localparam int DATA_W = 32;

    logic clk;
    logic rst;

    div_iter_if #(.DATA_W(DATA_W)) bus ();

    div_iter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          vectors    = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    // Reference quotient/remainder from 64-bit truncating arithmetic.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint la;
        longint lb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sd) begin
            la = $signed(a);
            lb = $signed(b);
        end else begin
            la = {32'd0, a};
            lb = {32'd0, b};
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp);
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.opdata1    = a;
        bus.opdata2    = b;
        exp_q.push_back(exp);
        lat_q.push_back((b == 32'd0) ? 1 : DATA_W);
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom;
    endtask

    task automatic checkOutput(input string tag);
        int          k;
        int          lat;
        logic [63:0] exp;
        k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        exp = exp_q.pop_front();
        lat = lat_q.pop_front();
        compare({tag, " latency"}, 64'(k), 64'(lat));
        compare({tag, " result"}, bus.result, exp);
        @(negedge clk);
        compare({tag, " pulse"}, {63'd0, bus.ready}, 64'd0);
    endtask

    task automatic quietCycles(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) highs++;
        end
    endtask

    initial begin
        logic [63:0] held;
        logic [63:0] exp_b;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsd;
        int          highs;
        int          k;
        int          gap;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        compare("reset ready", {63'd0, bus.ready}, 64'd0);
        compare("reset result", bus.result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed divides");
        applyStimulus(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        checkOutput("divu 100/7");
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        checkOutput("div -7/2");
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
        checkOutput("div 7/-2");
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        checkOutput("div min/-1");
        applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0});
        checkOutput("divu min/max");
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
        checkOutput("divu max/1");
        applyStimulus(1'b1, 32'd5, 32'd0, 64'd0);
        checkOutput("div by zero");
        applyStimulus(1'b0, 32'd5, 32'd0, 64'd0);
        checkOutput("divu by zero");

        $display("[TB] random divides");
        for (int i = 0; i < 6; i++) begin
            rsd = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd3 : $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd13;
            applyStimulus(rsd, ra, rb, model(rsd, ra, rb));
            checkOutput("random");
        end

        $display("[TB] annul in busy cycle 10");
        held           = bus.result;
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        quietCycles(40, highs);
        compare("annul busy no ready", 64'(highs), 64'd0);
        compare("annul busy result held", bus.result, held);
        applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
        checkOutput("divu 9/3 after annul");

        $display("[TB] annul on final step");
        bus.start   = 1'b1;
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (DATA_W - 1) @(negedge clk);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        quietCycles(40, highs);
        compare("annul last no ready", 64'(highs), 64'd0);
        compare("annul last result held", bus.result, {32'd0, 32'd3});

        $display("[TB] annul with start in idle");
        bus.start   = 1'b1;
        bus.annul   = 1'b1;
        bus.opdata1 = 32'd8;
        bus.opdata2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.annul = 1'b0;
        quietCycles(40, highs);
        compare("annul idle no ready", 64'(highs), 64'd0);
        compare("annul idle result held", bus.result, {32'd0, 32'd3});

        $display("[TB] back-to-back");
        exp_b          = model(1'b1, 32'hFFFFFF9C, 32'd7);
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd10;
        exp_q.push_back({32'd0, 32'd100});
        lat_q.push_back(DATA_W);
        @(posedge clk);
        @(negedge clk);
        bus.signed_div = 1'b1;
        bus.opdata1    = 32'hFFFFFF9C;
        bus.opdata2    = 32'd7;
        k = 0;
        while (bus.ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        compare("b2b first latency", 64'(k), 64'(lat_q.pop_front()));
        compare("b2b first result", bus.result, exp_q.pop_front());
        bus.start = 1'b0;
        exp_q.push_back(exp_b);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            if (gap == 1) bus.start = 1'b1;
            if (gap == 2) bus.start = 1'b0;
        end while (bus.ready !== 1'b1 && gap < 100);
        compare("b2b ready spacing", 64'(gap), 64'(DATA_W + 2));
        compare("b2b second result", bus.result, exp_q.pop_front());
        @(negedge clk);
        compare("b2b second pulse", {63'd0, bus.ready}, 64'd0);

        $display("[TB] reset mid-busy");
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd77;
        bus.opdata2    = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        compare("mid reset ready", {63'd0, bus.ready}, 64'd0);
        compare("mid reset result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quietCycles(40, highs);
        compare("after reset no ready", 64'(highs), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
